// File: rtl/call_stack_ctrl.sv
// Return-address stack sequencer: arbitrates INT/CALL pushes and RET pops,
// owns the entry storage and pointer, and flags overflow/underflow.
module call_stack_ctrl #(
  parameter int AW   = 8,
  parameter int DLOG = 3
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            INT_REQ,
  input  logic [AW-1:0]   INT_ADDR,
  input  logic            CALL_REQ,
  input  logic [AW-1:0]   CALL_ADDR,
  input  logic            RET_REQ,
  input  logic            ERR_CLR,
  output logic            BUSY,
  output logic            ACK,
  output logic [1:0]      GNT,
  output logic [AW-1:0]   RET_ADDR,
  output logic            RET_VALID,
  output logic [DLOG:0]   SP,
  output logic            FULL,
  output logic            EMPTY,
  output logic            OVF,
  output logic            UNF
);

  localparam int            DEPTH   = 1 << DLOG;
  localparam logic [DLOG:0] SP_MAX  = (DLOG+1)'(DEPTH);
  localparam logic [DLOG:0] SP_ONE  = (DLOG+1)'(1);
  localparam logic [DLOG-1:0] IDX_ONE = DLOG'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PUSH = 2'd1;
  localparam logic [1:0] S_POP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] G_INT  = 2'b01;
  localparam logic [1:0] G_CALL = 2'b10;
  localparam logic [1:0] G_RET  = 2'b11;

  logic [1:0]      state;
  logic [1:0]      gnt;
  logic [DLOG:0]   sp;
  logic [AW-1:0]   ret_addr;
  logic            ret_valid;
  logic            ovf;
  logic            unf;
  logic [AW-1:0]   push_addr_p0;
  logic [AW-1:0]   mem [DEPTH];

  logic            full;
  logic            empty;
  logic [DLOG-1:0] wr_idx;
  logic [DLOG-1:0] top_idx;

  assign full    = (sp == SP_MAX);
  assign empty   = (sp == '0);
  assign wr_idx  = sp[DLOG-1:0];
  // At SP==DEPTH the low bits are zero, so subtracting one still lands on the top entry.
  assign top_idx = sp[DLOG-1:0] - IDX_ONE;

  // Control: arbitration, pointer, status and sticky errors
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= S_IDLE;
      gnt       <= 2'b00;
      sp        <= '0;
      ret_addr  <= '0;
      ret_valid <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      ret_valid <= 1'b0;
      if (ERR_CLR) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (INT_REQ) begin
            gnt   <= G_INT;
            state <= S_PUSH;
          end else if (CALL_REQ) begin
            gnt   <= G_CALL;
            state <= S_PUSH;
          end else if (RET_REQ) begin
            gnt   <= G_RET;
            state <= S_POP;
          end
        end
        S_PUSH: begin
          if (full) ovf <= 1'b1;
          else      sp  <= sp + SP_ONE;
          state <= S_DONE;
        end
        S_POP: begin
          if (empty) begin
            unf <= 1'b1;
          end else begin
            ret_addr  <= mem[top_idx];
            sp        <= sp - SP_ONE;
            ret_valid <= 1'b1;
          end
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data: push operand capture and entry storage (not reset)
  always_ff @(posedge Clk) begin
    if (state == S_IDLE) push_addr_p0 <= INT_REQ ? INT_ADDR : CALL_ADDR;
    if (Rst && (state == S_PUSH) && !full) mem[wr_idx] <= push_addr_p0;
  end

  assign BUSY      = (state != S_IDLE);
  assign ACK       = (state == S_DONE);
  assign GNT       = gnt;
  assign RET_ADDR  = ret_addr;
  assign RET_VALID = ret_valid;
  assign SP        = sp;
  assign FULL      = full;
  assign EMPTY     = empty;
  assign OVF       = ovf;
  assign UNF       = unf;

endmodule
